// File: rtl/lcm_pkg.sv
// rtl/lcm_pkg.sv - shared types and widths for the sequential LCM stage
package lcm_pkg;

    localparam int W     = 7;            // operand width, matches the upstream GCD block
    localparam int LCM_W = 2 * W;        // result width
    localparam int CNT_W = $clog2(W + 1); // step-counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/restoring_div_seq.sv
// rtl/restoring_div_seq.sv - W-cycle unsigned restoring divider, MSB first
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      load dividend/divisor and clear quotient, remainder and step count
//   dividend   W-bit unsigned dividend
//   divisor    W-bit unsigned divisor (non-zero when start is asserted)
//   done       high during the cycle in which the final step is taken
//   quotient   W-bit quotient, valid while done is high
//   remainder  W+1-bit remainder, valid while done is high
module restoring_div_seq
    import lcm_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   dividend,
    input  logic [W-1:0]   divisor,
    output logic           done,
    output logic [W-1:0]   quotient,
    output logic [W:0]     remainder
);

    logic [W:0]       rem_q;
    logic [W-1:0]     quo_q;
    logic [W-1:0]     dvd_q;
    logic [W-1:0]     dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    logic [W+1:0]     trial;
    logic             fits;
    logic [W:0]       rem_nxt;
    logic [W-1:0]     quo_nxt;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        trial   = {rem_q, dvd_q[W-1]};
        fits    = trial >= {2'b00, dvs_q};
        rem_nxt = (W + 1)'(fits ? trial - {2'b00, dvs_q} : trial);
        quo_nxt = W'({quo_q, fits});
    end

    // The last step is presented combinationally so the caller can decide on
    // the same edge that would otherwise register it.
    assign done      = busy_q && (cnt_q == CNT_W'(W - 1));
    assign quotient  = quo_nxt;
    assign remainder = rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= rem_nxt;
            quo_q  <= quo_nxt;
            dvd_q  <= dvd_q << 1;
            cnt_q  <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lcm_seq.sv
// rtl/lcm_seq.sv - multi-cycle LCM = (a / gcd) * b with valid/ready on both sides
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   a, b, gcd            W-bit operand triple, sampled on the accept edge
//   in_valid, in_ready   input handshake (in_ready only in IDLE)
//   lcm                  2W-bit result, held while out_valid
//   err                  gcd is zero or does not divide a
//   out_valid, out_ready output handshake
module lcm_seq
    import lcm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     gcd,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [LCM_W-1:0] lcm,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state_q, state_d;

    logic             bypass_zero;
    logic             bypass_err;
    logic             div_start;
    logic             div_done;
    logic [W-1:0]     div_quo;
    logic [W:0]       div_rem;

    logic [LCM_W-1:0] acc_q;
    logic [LCM_W-1:0] mc_q;   // b, shifted left one place per step
    logic [W-1:0]     mq_q;   // quotient, shifted right one place per step
    logic [CNT_W-1:0] cnt_q;
    logic [LCM_W-1:0] acc_nxt;
    logic             mul_last;

    assign bypass_zero = (a == '0) || (b == '0);
    assign bypass_err  = !bypass_zero && (gcd == '0);
    assign acc_nxt     = acc_q + (mq_q[0] ? mc_q : '0);
    assign mul_last    = (cnt_q == CNT_W'(W - 1));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    restoring_div_seq u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (a),
        .divisor   (gcd),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (bypass_zero || bypass_err) begin
                        state_d = DONE;
                    end else begin
                        div_start = 1'b1;
                        state_d   = DIV;
                    end
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d = (div_rem != '0) ? DONE : MUL;
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lcm     <= '0;
            err     <= 1'b0;
            acc_q   <= '0;
            mc_q    <= '0;
            mq_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        lcm  <= '0;
                        err  <= bypass_err;
                        mc_q <= {{W{1'b0}}, b};
                    end
                end
                DIV: begin
                    if (div_done) begin
                        if (div_rem != '0) begin
                            lcm <= '0;
                            err <= 1'b1;
                        end
                        mq_q  <= div_quo;
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                MUL: begin
                    acc_q <= acc_nxt;
                    mc_q  <= mc_q << 1;
                    mq_q  <= mq_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (mul_last) begin
                        lcm <= acc_nxt;
                        err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
